uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, number of byte entries; power of two, minimum 2, SHALL be enforced by elaboration-time check.
REQ-002 Port: CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-003 Port: RST_N  input  1  reset; SHALL be synchronous, active-low.
REQ-004 Port: wr_data  input  8  byte pushed by producer.
REQ-005 Port: wr_en  input  1  push request, sampled on posedge CLK.
REQ-006 Port: full  output  1  count == DEPTH.
REQ-007 Port: empty  output  1  count == 0.
REQ-008 Port: count  output  $clog2(DEPTH)+1  stored entries.
REQ-009 Port: tx_busy  input  1  Busy from the downstream serial sender.
REQ-010 Port: tx_data  output  8  byte presented to the sender's data_in.
REQ-011 Port: tx_we  output  1  one-cycle write strobe to the sender's WE.
REQ-012 Port: ovf  output  1  sticky overflow flag (macro-dependent).
REQ-013 Port: ovf_clr  input  1  clears ovf (macro-dependent).

Function
REQ-014 Storage SHALL be a circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-015 Push: wr_en=1 and full=0 at an edge SHALL store wr_data at wr_ptr and advance wr_ptr.
REQ-016 Push while full SHALL be dropped (no pointer or count change), even if a pop occurs on the same edge.
REQ-017 Pop SHALL occur only on the IDLE->ISSUE transition: tx_data <= head entry, rd_ptr advances.
REQ-018 Simultaneous accepted push and pop SHALL leave count unchanged; full/empty/count SHALL be registered-state derived (no combinational path from wr_en).
REQ-019 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> ISSUE when empty=0 and tx_busy=0; otherwise stay.
REQ-021 ISSUE -> WAIT_BUSY unconditionally; tx_we SHALL be 1 exactly while in ISSUE, 0 in all other states.
REQ-022 WAIT_BUSY -> WAIT_DONE when tx_busy=1; otherwise stay.
REQ-023 WAIT_DONE -> IDLE when tx_busy=0; otherwise stay.
REQ-024 tx_data SHALL remain stable from ISSUE entry until the next pop.
REQ-025 Latency: byte pushed into empty FIFO with FSM in IDLE at edge N SHALL give tx_we=1 in the cycle after edge N+1.
REQ-026 tx_we SHALL never be asserted while tx_busy=1 or before the previous frame's Busy has fallen.

Reset
REQ-027 RST_N=0 at an edge SHALL force: state IDLE, pointers 0, count 0, empty 1, full 0, tx_we 0, tx_data 8'h00, ovf 0; stored contents discarded.
REQ-028 Reset mid-transfer SHALL abort without issuing tx_we; FSM SHALL return to IDLE regardless of tx_busy.

Configuration
REQ-029 Macro UART_TX_FIFO_OVF_FLAG_EN defined: ovf SHALL set on any dropped push (REQ-016) and hold until ovf_clr=1 at an edge; set and clear on the same edge -> set wins.
REQ-030 Macro undefined: ovf SHALL be constant 0, ovf_clr ignored, drop behaviour unchanged.

Verification
REQ-031 Reset, push 8'hA5 to empty FIFO at edge N, tx_busy held 0 -> tx_we=1 for exactly one cycle after edge N+1, tx_data=8'hA5, count back to 0.
REQ-032 DEPTH=16, tx_busy=1 throughout, push 17 bytes 8'h00..8'h10 -> count=16, full=1, 8'h10 dropped, ovf=1 (macro on) / ovf=0 (macro off).
REQ-033 Connected to serial sender (WAIT_DIV=4), push 3 bytes back-to-back -> three tx_we pulses, each only after Busy fell; line carries 8'h..,8'h..,8'h.. in order, no lost frames.
REQ-034 Full FIFO in IDLE, tx_busy=0, push on same edge as pop -> push dropped, count=15, full=0 next cycle.
REQ-035 Assert RST_N=0 while in WAIT_DONE with 5 entries -> next cycle count=0, empty=1, tx_we=0, IDLE.
REQ-036 Pointer wrap: push/drain 40 bytes in random bursts with DEPTH=16 -> output order equals input order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a serial sender through a WE/Busy handshake.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_FLAG_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_we,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        mem_q [DEPTH];
  logic              push_ok;
  logic              pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign tx_data = tx_data_q;
  assign tx_we   = (state_q == StIssue);

  // full is registered, so a pop on the same edge cannot rescue a push.
  assign push_ok = wr_en && !full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) begin
          state_d = StIssue;
          pop     = 1'b1;
        end
      end
      StIssue:    state_d = StWaitBusy;
      StWaitBusy: if (tx_busy) state_d = StWaitDone;
      StWaitDone: if (!tx_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    count_d   = count_q + CntW'(push_ok) - CntW'(pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (RST_N && push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule
